ad7606_frame_buf: RTL

//  Parametrised frame buffer behind the AD7606 capture engine (ad_data_valid + per-channel words).

---
 rtl/ad7606_pkg.sv | 14 +
 rtl/ad7606_fb_ram.sv | 26 ++
 rtl/ad7606_frame_buf.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ad7606_pkg.sv
// Shared definitions for the AD7606 frame buffer: default sizes, writer
// state encoding and the overrun counter width.
package ad7606_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 8;
    localparam int OVR_W      = 16;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } wr_state_t;

endpackage

// File: rtl/ad7606_fb_ram.sv
// Simple dual-port frame RAM: one full conversion (all channels) per word,
// synchronous write, registered read. Contents are never reset.
module ad7606_fb_ram
    import ad7606_pkg::*;
#(
    parameter int WORD_W = DEF_NUM_CH * DEF_DATA_W,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Write port and registered read port; no reset on storage.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ad7606_frame_buf.sv
// Ping-pong frame buffer behind the AD7606 capture engine. Collects DEPTH
// conversions per bank, hands full banks to a reader in completion order via
// frame_ready/frame_ack, and counts frames lost to back-pressure.
// Optional feature: define AD7606_FB_TIMESTAMP_EN to add frame_ts.
module ad7606_frame_buf
    import ad7606_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ad_data_valid,
    input  logic [NUM_CH*DATA_W-1:0] ad_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     frame_done,
    output logic                     frame_ready,
    input  logic                     frame_ack,
    input  logic                     rd_en,
    input  logic [2:0]               rd_ch,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
`ifdef AD7606_FB_TIMESTAMP_EN
    output logic [31:0]              frame_ts,
`endif
    output logic [OVR_W-1:0]         overrun_cnt
);

    localparam int WORD_W = NUM_CH * DATA_W;
    localparam int ADDR_W = IDX_W + 1;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    wr_state_t          state_q, state_d;
    logic               wr_bank_q, rd_bank_q;
    logic [1:0]         full_q;
    logic [IDX_W-1:0]   wr_idx_q, drop_cnt_q;
    logic [NUM_CH-1:0]  mask_q, wr_mask;
    logic [OVR_W-1:0]   ovr_q;
    logic               done_q;
    logic               ack_acc, rd_acc, other_free, wr_en, last_wr;
    logic [WORD_W-1:0]  wr_word, ram_q;
    logic [2:0]         rd_ch_p1;
    logic               rd_vld_p1, rd_live_p1;
    logic [DATA_W-1:0]  rd_sel;

    assign frame_ready = full_q[rd_bank_q];
    assign ack_acc     = frame_ack & frame_ready;
    assign rd_acc      = rd_en & frame_ready;
    assign frame_done  = done_q;
    assign overrun_cnt = ovr_q;
    assign rd_valid    = rd_vld_p1;
    assign rd_data     = rd_live_p1 ? rd_sel : '0;

    // Writer next state; an ack in this cycle already counts as a free bank.
    always_comb begin
        state_d    = state_q;
        other_free = !full_q[~wr_bank_q] || (ack_acc && (rd_bank_q == ~wr_bank_q));
        wr_en      = (state_q == FILL) && ad_data_valid;
        last_wr    = wr_en && (wr_idx_q == IDX_W'(DEPTH - 1));
        unique case (state_q)
            FILL: if (last_wr && !other_free) state_d = DROP;
            DROP: if (other_free) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Writer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Channel mask is taken live on the first conversion, then held for the frame.
    always_comb begin
        wr_mask = (wr_idx_q == '0) ? ch_mask : mask_q;
        wr_word = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (wr_mask[c]) wr_word[c*DATA_W +: DATA_W] = ad_data[c*DATA_W +: DATA_W];
    end

    // Bank bookkeeping, write index, drop counting and frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            wr_idx_q   <= '0;
            drop_cnt_q <= '0;
            mask_q     <= '0;
            ovr_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_wr;
            if (ack_acc) begin
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= ~rd_bank_q;
            end
            if (last_wr) full_q[wr_bank_q] <= 1'b1;
            if (wr_en) begin
                wr_idx_q <= wr_idx_q + 1'b1;
                if (wr_idx_q == '0) mask_q <= ch_mask;
            end
            if (last_wr && other_free) wr_bank_q <= ~wr_bank_q;
            if (state_q == DROP) begin
                if (ad_data_valid) begin
                    if (drop_cnt_q == IDX_W'(DEPTH - 1)) begin
                        drop_cnt_q <= '0;
                        ovr_q      <= sat_inc(ovr_q);
                    end else begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                end
                if (other_free) begin
                    wr_bank_q  <= ~wr_bank_q;
                    wr_idx_q   <= '0;
                    drop_cnt_q <= '0;
                end
            end
        end
    end

    ad7606_fb_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank_q, wr_idx_q}),
        .wdata (wr_word),
        .re    (rd_acc),
        .raddr ({rd_bank_q, rd_idx}),
        .rdata (ram_q)
    );

    // Read stage p1: remember the channel and flag alongside the RAM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_live_p1 <= 1'b0;
            rd_ch_p1   <= '0;
        end else begin
            rd_vld_p1 <= rd_acc;
            if (rd_acc) begin
                rd_ch_p1   <= rd_ch;
                rd_live_p1 <= 1'b1;
            end
        end
    end

    // Channel slice after the RAM register; channels beyond NUM_CH read 0.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_ch_p1 == 3'(c)) rd_sel = ram_q[c*DATA_W +: DATA_W];
    end

`ifdef AD7606_FB_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_bank_q [2];

    // Free-running cycle counter, latched per bank on the frame's first conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q     <= '0;
            ts_bank_q[0] <= '0;
            ts_bank_q[1] <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (wr_en && (wr_idx_q == '0)) ts_bank_q[wr_bank_q] <= ts_cnt_q;
        end
    end

    assign frame_ts = frame_ready ? ts_bank_q[rd_bank_q] : '0;
`endif

endmodule
